// File: rtl/pwr_seq_pkg.sv
// Shared types for the MIPS core power-domain sequencer.
// The state encoding is also seen by power_manager and the test bench.
package pwr_seq_pkg;

  typedef enum logic [3:0] {
    RUN     = 4'd0,
    CLK_OFF = 4'd1,
    ISO_ON  = 4'd2,
    SAVE    = 4'd3,
    SW_OFF  = 4'd4,
    SLEEP   = 4'd5,
    SW_ON   = 4'd6,
    RESTORE = 4'd7,
    ISO_OFF = 4'd8
  } pwr_state_t;

endpackage

// File: rtl/seq_timer.sv
// Loadable down-counter used to time settle, pulse-width and ack-wait
// intervals. It stops at zero, and done is high while the count is zero.
module seq_timer #(
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             done
);

  logic [CNT_W-1:0] count;

  // Count down to zero. A load takes priority over counting.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/power_sequencer.sv
// Power-down / power-up sequencer for the MIPS core domain.
// It orders the clock gate, isolation, retention save/restore and the header
// switch. The switch chain reports completion through sw_ack, and a wait that
// runs past ACK_TIMEOUT sets a sticky fault.
//
// The timer is loaded with (interval - 1) on entry to a timed state. A state
// held for N cycles therefore leaves on the N-th edge after entry.
module power_sequencer
  import pwr_seq_pkg::*;
#(
  parameter int ISO_SETTLE     = 2,
  parameter int SAVE_CYCLES    = 1,
  parameter int RESTORE_CYCLES = 1,
  parameter int ACK_TIMEOUT    = 16,
  parameter int CNT_W          = 5
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       sw_ctrl_net,
  input  logic       sw_ack,
  output logic       clk_en,
  output logic       iso_enable,
  output logic       ret_save,
  output logic       ret_restore,
  output logic       sw_enable,
  output logic       busy,
  output logic       fault,
  output logic [3:0] pwr_state
);

  localparam logic [CNT_W-1:0] ISO_LD     = CNT_W'(ISO_SETTLE - 1);
  localparam logic [CNT_W-1:0] SAVE_LD    = CNT_W'(SAVE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RESTORE_LD = CNT_W'(RESTORE_CYCLES - 1);
  localparam logic [CNT_W-1:0] ACK_LD     = CNT_W'(ACK_TIMEOUT - 1);

  pwr_state_t       state;
  logic             t_load;
  logic [CNT_W-1:0] t_val;
  logic             t_done;

  seq_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (t_load),
    .load_val (t_val),
    .done     (t_done)
  );

  // Arm the timer on the same edge that enters a timed state.
  always_comb begin
    t_load = 1'b0;
    t_val  = '0;
    case (state)
      CLK_OFF: begin
        t_load = 1'b1;
        t_val  = ISO_LD;
      end
      ISO_ON: if (t_done) begin
        t_load = 1'b1;
        t_val  = SAVE_LD;
      end
      SAVE: if (t_done) begin
        t_load = 1'b1;
        t_val  = ACK_LD;
      end
      SLEEP: if (!sw_ctrl_net) begin
        t_load = 1'b1;
        t_val  = ACK_LD;
      end
      SW_ON: if (sw_ack || t_done) begin
        t_load = 1'b1;
        t_val  = RESTORE_LD;
      end
      RESTORE: if (t_done) begin
        t_load = 1'b1;
        t_val  = ISO_LD;
      end
      default: ;
    endcase
  end

  // Sequencing FSM. Every output is registered with the state that owns it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= RUN;
      clk_en      <= 1'b1;
      iso_enable  <= 1'b0;
      ret_save    <= 1'b0;
      ret_restore <= 1'b0;
      sw_enable   <= 1'b1;
      busy        <= 1'b0;
      fault       <= 1'b0;
    end else begin
      case (state)
        RUN: if (sw_ctrl_net) begin
          state  <= CLK_OFF;
          clk_en <= 1'b0;
          busy   <= 1'b1;
        end
        CLK_OFF: begin
          state      <= ISO_ON;
          iso_enable <= 1'b1;
        end
        ISO_ON: if (t_done) begin
          state    <= SAVE;
          ret_save <= 1'b1;
        end
        SAVE: if (t_done) begin
          state     <= SW_OFF;
          ret_save  <= 1'b0;
          sw_enable <= 1'b0;
        end
        // Leave on ack low, or on timeout with the ack still high (fault).
        SW_OFF: if (!sw_ack || t_done) begin
          state <= SLEEP;
          busy  <= 1'b0;
          if (sw_ack) fault <= 1'b1;
        end
        SLEEP: if (!sw_ctrl_net) begin
          state     <= SW_ON;
          sw_enable <= 1'b1;
          busy      <= 1'b1;
        end
        SW_ON: if (sw_ack || t_done) begin
          state       <= RESTORE;
          ret_restore <= 1'b1;
          if (!sw_ack) fault <= 1'b1;
        end
        RESTORE: if (t_done) begin
          state       <= ISO_OFF;
          ret_restore <= 1'b0;
          iso_enable  <= 1'b0;
        end
        ISO_OFF: if (t_done) begin
          state  <= RUN;
          clk_en <= 1'b1;
          busy   <= 1'b0;
        end
        // Unused encodings fall back to the powered, running state.
        default: begin
          state       <= RUN;
          clk_en      <= 1'b1;
          iso_enable  <= 1'b0;
          ret_save    <= 1'b0;
          ret_restore <= 1'b0;
          sw_enable   <= 1'b1;
          busy        <= 1'b0;
        end
      endcase
    end
  end

  assign pwr_state = state;

endmodule
